// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall detection for an in-order five-stage core.
//
// Raises a stall when the instruction in ID reads a register that a load in
// EX has not yet produced (load-use). With HAZARD_BRANCH_STALL_EN defined it
// also stalls a branch in ID whose operands are still being produced by the
// EX instruction or by a load in MEM. Register 0 never causes a hazard.
//
// Optional feature macro: HAZARD_BRANCH_STALL_EN (undefined by default).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ID_EX_MemRead       EX instruction is a load
//   ID_EX_RegRt         load destination in EX
//   IF_ID_RegRs/RegRt   source registers of the ID instruction
//   IF_ID_Branch        ID instruction is a branch          (branch stall only)
//   ID_EX_RegWrite      EX instruction writes a register    (branch stall only)
//   ID_EX_RegRd         EX write destination                (branch stall only)
//   EX_MEM_MemRead      MEM instruction is a load           (branch stall only)
//   EX_MEM_RegRd        MEM load destination                (branch stall only)
//   PCWrite             1 = PC may update
//   IF_ID_Write         1 = IF/ID may load
//   Mux_Select_Stall    1 = insert a bubble into ID/EX
//   stall_count         saturating count of stalled cycles
module hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRt,
  input  logic                  IF_ID_Branch,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegRd,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_RegRd,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  Mux_Select_Stall,
  output logic [CNT_W-1:0]      stall_count
);

  logic             load_use;
  logic             branch_hz;
  logic             stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign load_use = ID_EX_MemRead && (ID_EX_RegRt != '0) &&
                    ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));

`ifdef HAZARD_BRANCH_STALL_EN
  logic ex_dep;
  logic mem_dep;

  // A branch resolves in ID, so it must wait for any operand still in flight.
  assign ex_dep  = ID_EX_RegWrite && (ID_EX_RegRd != '0) &&
                   ((ID_EX_RegRd == IF_ID_RegRs) || (ID_EX_RegRd == IF_ID_RegRt));
  assign mem_dep = EX_MEM_MemRead && (EX_MEM_RegRd != '0) &&
                   ((EX_MEM_RegRd == IF_ID_RegRs) || (EX_MEM_RegRd == IF_ID_RegRt));
  assign branch_hz = IF_ID_Branch && (ex_dep || mem_dep);
`else
  logic unused_branch_inputs;

  // Branch-related ports stay on the interface but have no effect here.
  assign unused_branch_inputs = ^{IF_ID_Branch, ID_EX_RegWrite, ID_EX_RegRd,
                                  EX_MEM_MemRead, EX_MEM_RegRd};
  assign branch_hz = 1'b0;
`endif

  assign stall = load_use || branch_hz;

  // Reset holds the pipeline frozen; outputs follow rst_n without waiting for clk.
  always_comb begin
    PCWrite          = ~stall;
    IF_ID_Write      = ~stall;
    Mux_Select_Stall = stall;
    if (!rst_n) begin
      PCWrite          = 1'b0;
      IF_ID_Write      = 1'b0;
      Mux_Select_Stall = 1'b1;
    end
  end

  // Saturating counter: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Two instances share stimulus: one with
// the default 16-bit counter and one with a 4-bit counter for saturation.
module tb_hazard_unit;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        mux;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       memrd;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       br, regw;
  logic [4:0] ex_rd;
  logic       mem_mr;
  logic [4:0] mem_rd;

  logic        pcw16, ifw16, mux16;
  logic [15:0] cnt16;
  logic        pcw4, ifw4, mux4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [15:0] m16;
  logic [3:0]  m4;

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut16 (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (memrd),
    .ID_EX_RegRt      (ex_rt),
    .IF_ID_RegRs      (id_rs),
    .IF_ID_RegRt      (id_rt),
    .IF_ID_Branch     (br),
    .ID_EX_RegWrite   (regw),
    .ID_EX_RegRd      (ex_rd),
    .EX_MEM_MemRead   (mem_mr),
    .EX_MEM_RegRd     (mem_rd),
    .PCWrite          (pcw16),
    .IF_ID_Write      (ifw16),
    .Mux_Select_Stall (mux16),
    .stall_count      (cnt16)
  );

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_EX_MemRead    (memrd),
    .ID_EX_RegRt      (ex_rt),
    .IF_ID_RegRs      (id_rs),
    .IF_ID_RegRt      (id_rt),
    .IF_ID_Branch     (br),
    .ID_EX_RegWrite   (regw),
    .ID_EX_RegRd      (ex_rd),
    .EX_MEM_MemRead   (mem_mr),
    .EX_MEM_RegRd     (mem_rd),
    .PCWrite          (pcw4),
    .IF_ID_Write      (ifw4),
    .Mux_Select_Stall (mux4),
    .stall_count      (cnt4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    logic lu, bh;
    lu = memrd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    bh = 1'b0;
`ifdef HAZARD_BRANCH_STALL_EN
    bh = br && ((regw && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt))) ||
                (mem_mr && (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt))));
`endif
    return lu || bh;
  endfunction

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, ".pcw"}, 32'(pcw16), 32'(e.pcw));
    check_eq({tag, ".ifw"}, 32'(ifw16), 32'(e.ifw));
    check_eq({tag, ".mux"}, 32'(mux16), 32'(e.mux));
    check_eq({tag, ".cnt16"}, 32'(cnt16), 32'(e.c16));
    check_eq({tag, ".pcw4"}, 32'(pcw4), 32'(e.pcw));
    check_eq({tag, ".cnt4"}, 32'(cnt4), 32'(e.c4));
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model count.
  task automatic apply(input string tag, input logic rst, input logic m, input logic [4:0] xr,
                       input logic [4:0] s, input logic [4:0] t, input logic b, input logic w,
                       input logic [4:0] xd, input logic mm, input logic [4:0] md);
    exp_t e;
    logic st;
    @(negedge clk);
    rst_n = rst; memrd = m; ex_rt = xr; id_rs = s; id_rt = t;
    br = b; regw = w; ex_rd = xd; mem_mr = mm; mem_rd = md;
    #1;
    st = model_stall();
    if (!rst) begin
      m16 = '0;
      m4  = '0;
    end
    e.pcw = rst & ~st;
    e.ifw = rst & ~st;
    e.mux = ~rst | st;
    e.c16 = m16;
    e.c4  = m4;
    sb.push_back(e);
    compare_front(tag);
    @(posedge clk);
    #1;
    if (rst && st) begin
      if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
      if (m4 != 4'hF) m4 = m4 + 4'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
    br = 1'b0; regw = 1'b0; ex_rd = 5'd0; mem_mr = 1'b0; mem_rd = 5'd0;
    m16 = '0; m4 = '0;

    // Reset with hazard present and with quiet inputs.
    apply("rst_haz", 1'b0, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("rst_idle", 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2);
    apply("idle", 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Load-use on rs.
    for (int i = 0; i < 3; i++)
      apply("lu_rs", 1'b1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("r0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("no_load", 1'b1, 1'b0, 5'd3, 5'd4, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("lu_rt", 1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("no_match", 1'b1, 1'b1, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Branch dependencies: stall only when the branch feature is built in.
    apply("br_ex", 1'b1, 1'b0, 5'd0, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
    apply("br_mem", 1'b1, 1'b0, 5'd0, 5'd2, 5'd4, 1'b1, 1'b0, 5'd0, 1'b1, 5'd4);
    apply("br_r0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
    apply("nobr_ex", 1'b1, 1'b0, 5'd0, 5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9);

    // Random patterns over a small register range to force frequent matches.
    for (int i = 0; i < 40; i++)
      apply("rand", 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)));

    // Long stall: 4-bit counter must saturate at 15.
    for (int i = 0; i < 20; i++)
      apply("sat", 1'b1, 1'b1, 5'd8, 5'd1, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset mid-stall clears the count immediately; counting resumes after release.
    apply("rst_mid", 1'b0, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++)
      apply("post_rst", 1'b1, 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply("end_idle", 1'b1, 1'b0, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide parameter REG_ADDR_W, default 5, register-specifier width.
REQ-002 SHALL provide parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port list, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegRt  input  REG_ADDR_W  load destination register in EX.
- IF_ID_RegRs  input  REG_ADDR_W  rs source of instruction in ID.
- IF_ID_RegRt  input  REG_ADDR_W  rt source of instruction in ID.
- IF_ID_Branch  input  1  instruction in ID is a branch.
- ID_EX_RegWrite  input  1  EX instruction writes a register.
- ID_EX_RegRd  input  REG_ADDR_W  EX write destination.
- EX_MEM_MemRead  input  1  MEM instruction is a load.
- EX_MEM_RegRd  input  REG_ADDR_W  MEM load destination.
- PCWrite  output  1  1 = PC may update; 0 = hold PC.
- IF_ID_Write  output  1  1 = IF/ID may load; 0 = hold IF/ID.
- Mux_Select_Stall  output  1  1 = zero the control signals entering ID/EX (bubble).
- stall_count  output  CNT_W  registered count of stall cycles.

Function
REQ-005 load_use SHALL be 1 iff ID_EX_MemRead=1, ID_EX_RegRt!=0, and ID_EX_RegRt equals IF_ID_RegRs or IF_ID_RegRt.
REQ-006 Register 0 SHALL never cause a hazard.
REQ-007 stall SHALL be load_use OR branch_hz, where branch_hz is defined in REQ-016 and is 0 when that feature is compiled out.
REQ-008 Outputs SHALL be combinational in the same cycle with zero latency:
- PCWrite = ~stall
- IF_ID_Write = ~stall
- Mux_Select_Stall = stall
REQ-009 The three stall outputs SHALL be mutually consistent at all times: PCWrite equals IF_ID_Write, and Mux_Select_Stall equals their inverse.
REQ-010 Inputs with X/Z SHALL NOT be resolved specially; the bench drives known values only.
REQ-011 stall_count SHALL increment by 1 on each rising clk edge where stall=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-012 A stall SHALL last exactly as long as its condition is present; no internal hold or extension.

Reset
REQ-013 While rst_n=0, regardless of clk:
- stall_count SHALL be 0.
- PCWrite and IF_ID_Write SHALL be forced to 0.
- Mux_Select_Stall SHALL be forced to 1.
REQ-014 After rst_n deasserts, normal combinational behaviour SHALL resume immediately, and counting SHALL start at the next rising edge.
REQ-015 Reset asserted mid-stall SHALL clear stall_count at once; reset outputs take priority.

Configuration
REQ-016 Macro HAZARD_BRANCH_STALL_EN, when defined, SHALL add branch_hz = IF_ID_Branch AND (X OR Y):
- X = ID_EX_RegWrite and ID_EX_RegRd!=0 and ID_EX_RegRd matches IF_ID_RegRs or IF_ID_RegRt.
- Y = EX_MEM_MemRead and EX_MEM_RegRd!=0 and EX_MEM_RegRd matches IF_ID_RegRs or IF_ID_RegRt.
REQ-017 Without the macro, branch_hz SHALL be 0, and IF_ID_Branch, ID_EX_RegWrite, ID_EX_RegRd, EX_MEM_MemRead and EX_MEM_RegRd SHALL be ignored; the ports remain present.

Verification
REQ-018 rst_n=0 with any inputs -> PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1, stall_count=0.
REQ-019 ID_EX_MemRead=1, ID_EX_RegRt=5, IF_ID_RegRs=5, IF_ID_RegRt=7 -> PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1; stall_count +1 per edge.
REQ-020 ID_EX_MemRead=1, ID_EX_RegRt=0, IF_ID_RegRs=0, IF_ID_RegRt=0 -> PCWrite=1, IF_ID_Write=1, Mux_Select_Stall=0.
REQ-021 ID_EX_MemRead=0, ID_EX_RegRt=3, IF_ID_RegRt=3 -> no stall (PCWrite=1); and ID_EX_MemRead=1, RegRt=3, RegRs=4, IF_ID_RegRt=3 -> stall.
REQ-022 CNT_W=4, stall held for 20 cycles -> stall_count reaches 15 and stays at 15.
REQ-023 With the macro: IF_ID_Branch=1, ID_EX_RegWrite=1, ID_EX_RegRd=9, IF_ID_RegRs=9 -> stall. Without the macro -> no stall.
